scoreboard_forward_unit: RTL and testbench
==========================================

# scoreboard_forward_unit

Parametrised successor to the pipeline forwarding unit: generates per-operand bypass selects for NUM_SRC source operands in EX, and adds a per-register latency scoreboard that stalls the instruction in ID until each of its producers' results can be forwarded. The block sits between ID/EX issue control and the EX operand muxes. It covers single-cycle ALU ops, loads and a long-latency (mul/div) result bus.

## Interface
- NUM_SRC, 2, number of source operands per instruction (1..4).
- ADDR_W, 5, register address width; register file has 2**ADDR_W entries, x0 hard-wired zero.
- MAX_LAT, 8, maximum producer latency tracked; counter width LAT_W = $clog2(MAX_LAT+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- issue_valid  in  1  instruction in ID requests to advance into EX.
- issue_reg_write  in  1  issuing instruction writes rd.
- issue_rd_addr  in  ADDR_W  destination of issuing instruction.
- issue_lat  in  LAT_W  cycles from issue until result is forwardable (ALU 1, load 2, mul/div up to MAX_LAT).
- flush  in  1  pipeline flush; suppresses issue this cycle.
- id_rs_addr  in  NUM_SRC*ADDR_W  ID source addresses, operand i at [i*ADDR_W +: ADDR_W].
- id_rs_used  in  NUM_SRC  operand i is actually read.
- ex_rs_addr  in  NUM_SRC*ADDR_W  EX source addresses.
- ex_mem_reg_write, ex_mem_rd_addr  in  1, ADDR_W  EX/MEM producer.
- mem_wb_reg_write, mem_wb_rd_addr  in  1, ADDR_W  MEM/WB producer.
- lr_valid, lr_rd_addr  in  1, ADDR_W  long-latency result bus.
- forward_sel  out  2*NUM_SRC  per-operand select, operand i at [2*i +: 2].
- stall  out  1  hold ID, inject bubble into EX.
- issue_accept  out  1  issue_valid & ~stall & ~flush.
- stall_cycles  out  32  stall performance counter (see Configuration).

## Operation
- Forwarding (combinational, per operand i, priority order): EX/MEM match with reg_write and rd≠0 → 2'b10; else MEM/WB match → 2'b01; else lr_valid match, rd≠0 → 2'b11; else 2'b00 (register file).
- Scoreboard: busy[r], LAT_W bits, one per register; busy[0] never written.
- Every cycle each nonzero busy[r] decrements by 1.
- On issue_accept with issue_reg_write and issue_rd_addr≠0: busy[rd] <= max(issue_lat clamped to MAX_LAT, busy[rd]−1 saturating at 0). This is the WAW rule: the longer-outstanding producer governs.
- stall = 1 when any operand i has id_rs_used[i]=1, id_rs_addr_i≠0 and busy[id_rs_addr_i] >= 2.
- issue_valid while stall=1 or flush=1 is not accepted and leaves the scoreboard unchanged except for decrement.
- flush does not clear busy; instructions already issued still complete.

## Timing
- Reset: all busy = 0, stall = 0, stall_cycles = 0. forward_sel and issue_accept are combinational from inputs.
- forward_sel, stall and issue_accept have zero latency from inputs and registered busy.
- Issue at edge t: ALU dependent (lat 1) in ID at t+1 sees busy=1 and does not stall; it forwards from EX/MEM.
- Load (lat 2): 1 stall cycle. Latency L in general: L−1 stall cycles for a back-to-back consumer.
- Reset asserted mid-operation clears all busy immediately; stall drops asynchronously.

## Configuration
- SB_PERF_CNT_EN defined: stall_cycles increments on every cycle with stall=1 and issue_valid=1, saturating at 32'hFFFF_FFFF, reset to 0.
- SB_PERF_CNT_EN undefined: no counter logic; stall_cycles tied to 32'h0.

## Test plan
- ALU chain: issue x5 (lat 1), next cycle ID reads x5 → stall=0; next cycle EX rs1=x5 with ex_mem_rd=x5 → forward_sel[1:0]=2'b10.
- Load-use: issue x7 (lat 2), ID rs2=x7 → stall=1 for exactly 1 cycle, issue_accept=0 then 1; stall_cycles=1 with SB_PERF_CNT_EN.
- Long latency: issue x9 (lat 6) → ID consumer stalls 5 cycles; in EX, lr_valid with lr_rd=x9 and no other match → 2'b11.
- Priority and x0: ex_mem_rd=mem_wb_rd=x3 → 2'b10. rd=x0 on all buses → 2'b00. Issue to x0 with lat 6 leaves busy[0]=0 and causes no stall.
- WAW and flush: issue x4 lat 6, then x4 lat 1 → stall persists for the lat-6 window. issue_valid with flush=1 → issue_accept=0, busy unchanged.
- Async reset: assert rst_n=0 while busy[x4]=5 and stall=1 → stall=0 before the next clock edge, all busy = 0.

Source files
------------

// File: rtl/scoreboard_forward_unit_if.sv
// scoreboard_forward_unit_if
// Bundles the issue, ID/EX operand and producer-bus signals of the scoreboard
// forwarding unit. The pipeline control side (master) drives the requests; the
// unit (slave) returns bypass selects, stall, issue acceptance and the stall
// performance counter.
interface scoreboard_forward_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
);
    logic                      issue_valid;
    logic                      issue_reg_write;
    logic [ADDR_W-1:0]         issue_rd_addr;
    logic [LAT_W-1:0]          issue_lat;
    logic                      flush;
    logic [NUM_SRC*ADDR_W-1:0] id_rs_addr;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [NUM_SRC*ADDR_W-1:0] ex_rs_addr;
    logic                      ex_mem_reg_write;
    logic [ADDR_W-1:0]         ex_mem_rd_addr;
    logic                      mem_wb_reg_write;
    logic [ADDR_W-1:0]         mem_wb_rd_addr;
    logic                      lr_valid;
    logic [ADDR_W-1:0]         lr_rd_addr;
    logic [2*NUM_SRC-1:0]      forward_sel;
    logic                      stall;
    logic                      issue_accept;
    logic [31:0]               stall_cycles;

    modport master (
        output issue_valid, issue_reg_write, issue_rd_addr, issue_lat, flush,
        output id_rs_addr, id_rs_used, ex_rs_addr,
        output ex_mem_reg_write, ex_mem_rd_addr,
        output mem_wb_reg_write, mem_wb_rd_addr,
        output lr_valid, lr_rd_addr,
        input  forward_sel, stall, issue_accept, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_reg_write, issue_rd_addr, issue_lat, flush,
        input  id_rs_addr, id_rs_used, ex_rs_addr,
        input  ex_mem_reg_write, ex_mem_rd_addr,
        input  mem_wb_reg_write, mem_wb_rd_addr,
        input  lr_valid, lr_rd_addr,
        output forward_sel, stall, issue_accept, stall_cycles
    );
endinterface

// File: rtl/scoreboard_forward_unit.sv
// scoreboard_forward_unit
// Per-operand EX bypass select generation plus a per-register latency
// scoreboard that holds an instruction in ID until every producer it reads
// is at most one cycle from being forwardable.
// Optional build macro: SB_PERF_CNT_EN adds a saturating stall-cycle counter;
// without it stall_cycles is tied to zero and no counter logic exists.
module scoreboard_forward_unit #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input logic                      clk,
    input logic                      rst_n,
    scoreboard_forward_unit_if.slave sb
);
    localparam int               NUM_REGS  = 1 << ADDR_W;
    localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0]     busy_q [NUM_REGS];
    logic [LAT_W-1:0]     busy_d [NUM_REGS];
    logic [LAT_W-1:0]     lat_clamped;
    logic                 wr_en;
    logic                 stall_c;
    logic                 accept_c;
    logic [2*NUM_SRC-1:0] fwd_c;

    // Bypass select per EX operand: EX/MEM beats MEM/WB beats long-latency bus.
    always_comb begin
        fwd_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sb.ex_mem_reg_write && (sb.ex_mem_rd_addr != '0) &&
                (sb.ex_mem_rd_addr == sb.ex_rs_addr[i*ADDR_W +: ADDR_W])) begin
                fwd_c[2*i +: 2] = 2'b10;
            end else if (sb.mem_wb_reg_write && (sb.mem_wb_rd_addr != '0) &&
                         (sb.mem_wb_rd_addr == sb.ex_rs_addr[i*ADDR_W +: ADDR_W])) begin
                fwd_c[2*i +: 2] = 2'b01;
            end else if (sb.lr_valid && (sb.lr_rd_addr != '0) &&
                         (sb.lr_rd_addr == sb.ex_rs_addr[i*ADDR_W +: ADDR_W])) begin
                fwd_c[2*i +: 2] = 2'b11;
            end
        end
    end

    // Stall while any used, nonzero source still needs two or more cycles;
    // a count of one means the result will be on a bypass path next cycle.
    always_comb begin
        stall_c = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sb.id_rs_used[i] && (sb.id_rs_addr[i*ADDR_W +: ADDR_W] != '0) &&
                (busy_q[sb.id_rs_addr[i*ADDR_W +: ADDR_W]] > LAT_W'(1))) begin
                stall_c = 1'b1;
            end
        end
    end

    // Issue acceptance and the clamped latency loaded on a write-back issue.
    always_comb begin
        accept_c    = sb.issue_valid && !stall_c && !sb.flush;
        lat_clamped = (sb.issue_lat > LAT_MAX_V) ? LAT_MAX_V : sb.issue_lat;
        wr_en       = accept_c && sb.issue_reg_write && (sb.issue_rd_addr != '0);
    end

    // Scoreboard next state: decrement every entry, then on a write the longer
    // of the new latency and the remaining older count wins (WAW ordering).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = '0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_d[r] = (busy_q[r] != '0) ? (busy_q[r] - LAT_W'(1)) : '0;
            if (wr_en && (sb.issue_rd_addr == ADDR_W'(r)) && (lat_clamped > busy_d[r])) begin
                busy_d[r] = lat_clamped;
            end
        end
    end

    // Scoreboard register; reset clears every entry so stall drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

    assign sb.forward_sel  = fwd_c;
    assign sb.stall        = stall_c;
    assign sb.issue_accept = accept_c;

`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Count cycles where a real request was held back, saturating at all ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_c && sb.issue_valid && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb.stall_cycles = stall_cycles_q;
`else
    assign sb.stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_scoreboard_forward_unit.sv
// tb_scoreboard_forward_unit
// Directed stimulus pushes hand-computed expectations into a queue; a monitor
// on the falling clock edge pops and compares them against the DUT outputs.
module tb_scoreboard_forward_unit;
    localparam int K_FWD    = 0;
    localparam int K_STALL  = 1;
    localparam int K_ACCEPT = 2;
    localparam int K_PERF   = 3;

    logic clk;
    logic rst_n;

    scoreboard_forward_unit_if #(.NUM_SRC(2), .ADDR_W(5), .MAX_LAT(8)) sbif ();

    scoreboard_forward_unit #(.NUM_SRC(2), .ADDR_W(5), .MAX_LAT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif)
    );

    string       name_q [$];
    int          kind_q [$];
    logic [31:0] val_q  [$];

    int n_tests = 0;
    int n_fail  = 0;
    int perf_exp = 0;
    bit cur_stall = 0;

    string       mon_name;
    int          mon_kind;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "timeout");
    end

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (kind_q.size() > 0) begin
            mon_name = name_q.pop_front();
            mon_kind = kind_q.pop_front();
            mon_exp  = val_q.pop_front();
            case (mon_kind)
                K_FWD:    mon_act = 32'(sbif.forward_sel);
                K_STALL:  mon_act = 32'(sbif.stall);
                K_ACCEPT: mon_act = 32'(sbif.issue_accept);
                default:  mon_act = sbif.stall_cycles;
            endcase
            n_tests++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got %0h required %0h", mon_name, mon_act, mon_exp);
            end
        end
    end

    task automatic expect_val(input string nm, input int kind, input logic [31:0] v);
        name_q.push_back(nm);
        kind_q.push_back(kind);
        val_q.push_back(v);
    endtask

    task automatic chk_stall(input string nm, input bit v);
        expect_val(nm, K_STALL, 32'(v));
        cur_stall = v;
    endtask

    task automatic chk_perf(input string nm);
`ifdef SB_PERF_CNT_EN
        expect_val(nm, K_PERF, 32'(perf_exp));
`else
        expect_val(nm, K_PERF, 32'h0);
`endif
    endtask

    task automatic clear_inputs();
        sbif.issue_valid      = 1'b0;
        sbif.issue_reg_write  = 1'b0;
        sbif.issue_rd_addr    = '0;
        sbif.issue_lat        = '0;
        sbif.flush            = 1'b0;
        sbif.id_rs_addr       = '0;
        sbif.id_rs_used       = '0;
        sbif.ex_rs_addr       = '0;
        sbif.ex_mem_reg_write = 1'b0;
        sbif.ex_mem_rd_addr   = '0;
        sbif.mem_wb_reg_write = 1'b0;
        sbif.mem_wb_rd_addr   = '0;
        sbif.lr_valid         = 1'b0;
        sbif.lr_rd_addr       = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
        sbif.issue_valid     = 1'b1;
        sbif.issue_reg_write = 1'b1;
        sbif.issue_rd_addr   = rd;
        sbif.issue_lat       = lat;
    endtask

    task automatic next();
        if (sbif.issue_valid && cur_stall) perf_exp++;
        cur_stall = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        sbif.id_rs_used = 2'b11;
        sbif.id_rs_addr = {5'd4, 5'd5};
        chk_stall("reset_stall", 1'b0);
        expect_val("reset_fwd", K_FWD, 32'h0);
        chk_perf("reset_perf");
        next();
        rst_n = 1'b1;

        // ALU chain
        clear_inputs(); issue(5'd5, 4'd1);
        expect_val("alu_issue_accept", K_ACCEPT, 32'h1);
        chk_stall("alu_issue_stall", 1'b0);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd5}; sbif.issue_valid = 1'b1;
        chk_stall("alu_dep_no_stall", 1'b0);
        expect_val("alu_dep_accept", K_ACCEPT, 32'h1);
        next();
        clear_inputs();
        sbif.ex_rs_addr = {5'd0, 5'd5}; sbif.ex_mem_reg_write = 1'b1; sbif.ex_mem_rd_addr = 5'd5;
        expect_val("alu_fwd_exmem", K_FWD, 32'h2);
        next();

        // Load-use
        clear_inputs(); issue(5'd7, 4'd2);
        expect_val("load_issue_accept", K_ACCEPT, 32'h1);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b10; sbif.id_rs_addr = {5'd7, 5'd0}; sbif.issue_valid = 1'b1;
        chk_stall("load_use_stall", 1'b1);
        expect_val("load_use_accept0", K_ACCEPT, 32'h0);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b10; sbif.id_rs_addr = {5'd7, 5'd0}; sbif.issue_valid = 1'b1;
        chk_stall("load_use_release", 1'b0);
        expect_val("load_use_accept1", K_ACCEPT, 32'h1);
        chk_perf("load_use_perf");
        next();

        // Long latency: 5 stall cycles for lat 6
        clear_inputs(); issue(5'd9, 4'd6);
        expect_val("long_issue_accept", K_ACCEPT, 32'h1);
        next();
        for (int k = 0; k < 6; k++) begin
            clear_inputs();
            sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd9}; sbif.issue_valid = 1'b1;
            chk_stall($sformatf("long_stall_c%0d", k), (k < 5));
            expect_val($sformatf("long_accept_c%0d", k), K_ACCEPT, (k < 5) ? 32'h0 : 32'h1);
            next();
        end
        chk_perf("long_perf");
        clear_inputs();
        sbif.ex_rs_addr = {5'd10, 5'd9};
        sbif.lr_valid = 1'b1; sbif.lr_rd_addr = 5'd9;
        sbif.mem_wb_reg_write = 1'b1; sbif.mem_wb_rd_addr = 5'd10;
        sbif.ex_mem_reg_write = 1'b1; sbif.ex_mem_rd_addr = 5'd12;
        expect_val("long_fwd_lr", K_FWD, 32'h7);
        next();

        // Priority and x0
        clear_inputs();
        sbif.ex_rs_addr = {5'd3, 5'd3};
        sbif.ex_mem_reg_write = 1'b1; sbif.ex_mem_rd_addr = 5'd3;
        sbif.mem_wb_reg_write = 1'b1; sbif.mem_wb_rd_addr = 5'd3;
        expect_val("prio_exmem_over_memwb", K_FWD, 32'hA);
        next();
        clear_inputs();
        sbif.ex_rs_addr = {5'd8, 5'd3};
        sbif.ex_mem_reg_write = 1'b1; sbif.ex_mem_rd_addr = 5'd8;
        sbif.mem_wb_reg_write = 1'b1; sbif.mem_wb_rd_addr = 5'd3;
        sbif.lr_valid = 1'b1; sbif.lr_rd_addr = 5'd3;
        expect_val("prio_mixed", K_FWD, 32'h9);
        next();
        clear_inputs();
        sbif.ex_rs_addr = {5'd6, 5'd6};
        sbif.mem_wb_reg_write = 1'b0; sbif.mem_wb_rd_addr = 5'd6;
        sbif.lr_valid = 1'b1; sbif.lr_rd_addr = 5'd6;
        expect_val("memwb_needs_write", K_FWD, 32'hF);
        next();
        clear_inputs();
        sbif.ex_mem_reg_write = 1'b1; sbif.mem_wb_reg_write = 1'b1; sbif.lr_valid = 1'b1;
        expect_val("x0_no_forward", K_FWD, 32'h0);
        next();
        clear_inputs(); issue(5'd0, 4'd6);
        expect_val("x0_issue_accept", K_ACCEPT, 32'h1);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b11; sbif.id_rs_addr = {5'd0, 5'd0};
        chk_stall("x0_no_stall", 1'b0);
        next();

        // Latency clamp: lat 15 behaves as MAX_LAT 8, 7 stall cycles
        clear_inputs(); issue(5'd11, 4'd15);
        next();
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            sbif.id_rs_used = 2'b10; sbif.id_rs_addr = {5'd11, 5'd0};
            chk_stall($sformatf("clamp_stall_c%0d", k), (k < 7));
            next();
        end

        // WAW: second, shorter write to x4 must not shorten the window
        clear_inputs(); issue(5'd4, 4'd6);
        next();
        clear_inputs(); issue(5'd4, 4'd1);
        expect_val("waw_second_accept", K_ACCEPT, 32'h1);
        next();
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd4};
            chk_stall($sformatf("waw_stall_c%0d", k), (k < 4));
            next();
        end

        // Flush suppresses issue and leaves the scoreboard alone
        clear_inputs(); issue(5'd6, 4'd6); sbif.flush = 1'b1;
        expect_val("flush_accept0", K_ACCEPT, 32'h0);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd6};
        chk_stall("flush_no_busy", 1'b0);
        next();

        // Async reset while stalled
        clear_inputs(); issue(5'd4, 4'd6);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd4};
        sbif.issue_valid = 1'b1; sbif.flush = 1'b1;
        chk_stall("pre_reset_stall_flush", 1'b1);
        next();
        clear_inputs();
        sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd4};
        rst_n = 1'b0;
        perf_exp = 0;
        chk_stall("async_reset_stall", 1'b0);
        chk_perf("async_reset_perf");
        next();
        rst_n = 1'b1;
        clear_inputs();
        sbif.id_rs_used = 2'b01; sbif.id_rs_addr = {5'd0, 5'd4};
        chk_stall("post_reset_busy_clear", 1'b0);
        chk_perf("post_reset_perf");
        next();

        @(negedge clk);
        #1;
        if (kind_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending required 0", kind_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
